// File: rtl/game_round_controller.sv
// game_round_controller: lives-aware round sequencer with registered pacman-ghost collision detection
module game_round_controller #(
  parameter int N_GHOSTS    = 4,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int HIT_RADIUS  = 16,
  parameter int MAX_LIVES   = 3,
  parameter int READY_TICKS = 120,
  parameter int DEATH_TICKS = 90,
  localparam int LW = $clog2(MAX_LIVES + 1),
  localparam int IW = (N_GHOSTS > 1) ? $clog2(N_GHOSTS) : 1,
  localparam int CW = $clog2(((READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS) + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start,
  input  logic [X_W-1:0]          pacman_x,
  input  logic [Y_W-1:0]          pacman_y,
  input  logic [N_GHOSTS*X_W-1:0] ghost_x,
  input  logic [N_GHOSTS*Y_W-1:0] ghost_y,
  input  logic [N_GHOSTS-1:0]     ghost_active,
  output logic [2:0]              state,
  output logic [LW-1:0]           lives,
  output logic                    move_en,
  output logic                    respawn,
  output logic                    pacman_is_dead,
  output logic [IW-1:0]           killer_id,
  output logic                    game_over
);
  typedef enum logic [2:0] {IDLE = 3'd0, READY = 3'd1, PLAY = 3'd2, DYING = 3'd3, GAME_OVER = 3'd4} state_t;
  localparam logic [X_W:0]    RX    = (X_W+1)'(HIT_RADIUS);
  localparam logic [Y_W:0]    RY    = (Y_W+1)'(HIT_RADIUS);
  localparam logic [LW-1:0]   LMAX  = LW'(MAX_LIVES);
  localparam logic [CW-1:0]   RLAST = CW'(READY_TICKS - 1);
  localparam logic [CW-1:0]   DLAST = CW'(DEATH_TICKS - 1);
  state_t              state_q, state_d;
  logic [LW-1:0]       lives_q, lives_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                move_en_q, move_en_d, respawn_q, respawn_d, hit_q;
  logic [IW-1:0]       killer_q, killer_d, kill_idx_q, kill_idx_d;
  logic [N_GHOSTS-1:0] hit_v;
  for (genvar g = 0; g < N_GHOSTS; g++) begin : g_hit
    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;
    logic [X_W:0]        ax;
    logic [Y_W:0]        ay;
    assign dx       = $signed({1'b0, pacman_x}) - $signed({1'b0, ghost_x[g*X_W +: X_W]});
    assign dy       = $signed({1'b0, pacman_y}) - $signed({1'b0, ghost_y[g*Y_W +: Y_W]});
    assign ax       = dx[X_W] ? -dx : dx;
    assign ay       = dy[Y_W] ? -dy : dy;
    assign hit_v[g] = ghost_active[g] && (ax < RX) && (ay < RY);
  end
  // descending scan so the lowest hitting ghost is the one that sticks
  always_comb begin
    kill_idx_d = '0;
    for (int i = N_GHOSTS - 1; i >= 0; i--) kill_idx_d = hit_v[i] ? IW'(i) : kill_idx_d;
  end
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    killer_d  = killer_q;
    move_en_d = 1'b0;
    respawn_d = 1'b0;
    case (state_q)
      IDLE, GAME_OVER: if (start) begin
        state_d   = READY;
        lives_d   = LMAX;
        respawn_d = 1'b1;
        cnt_d     = '0;
      end
      READY: if (tick) begin
        state_d = (cnt_q == RLAST) ? PLAY : READY;
        cnt_d   = (cnt_q == RLAST) ? '0 : cnt_q + 1'b1;
      end
      PLAY: if (hit_q) begin
        state_d  = DYING;
        lives_d  = (lives_q == '0) ? '0 : lives_q - 1'b1;
        killer_d = kill_idx_q;
        cnt_d    = '0;
      end else begin
        move_en_d = tick;
      end
      DYING: if (tick) begin
        state_d   = (cnt_q != DLAST) ? DYING : (lives_q == '0) ? GAME_OVER : READY;
        respawn_d = (cnt_q == DLAST) && (lives_q != '0);
        cnt_d     = (cnt_q == DLAST) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lives_q    <= LMAX;
      cnt_q      <= '0;
      move_en_q  <= 1'b0;
      respawn_q  <= 1'b0;
      killer_q   <= '0;
      hit_q      <= 1'b0;
      kill_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      cnt_q      <= cnt_d;
      move_en_q  <= move_en_d;
      respawn_q  <= respawn_d;
      killer_q   <= killer_d;
      hit_q      <= |hit_v;
      kill_idx_q <= kill_idx_d;
    end
  end
  assign state          = state_q;
  assign lives          = lives_q;
  assign move_en        = move_en_q;
  assign respawn        = respawn_q;
  assign killer_id      = killer_q;
  assign pacman_is_dead = (state_q == DYING);
  assign game_over      = (state_q == GAME_OVER);
endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller: directed + randomized checks against a countdown-based round model
module tb_game_round_controller;
  localparam int N = 4, XW = 11, YW = 10, R = 16, ML = 3, RT = 120, DT = 90;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, start = 1'b0;
  logic [XW-1:0] pacman_x = 11'd500;
  logic [YW-1:0] pacman_y = 10'd300;
  logic [N*XW-1:0] ghost_x = '0;
  logic [N*YW-1:0] ghost_y = '0;
  logic [N-1:0] ghost_active = '0;
  logic [2:0] state;
  logic [1:0] lives, killer_id;
  logic move_en, respawn, pacman_is_dead, game_over;
  int n_assert = 0, n_fail = 0;
  int m_state = 0, m_lives = ML, m_left = 0, m_killer = 0, m_kidx = 0;
  bit m_hit = 0, m_move = 0, m_resp = 0;

  game_round_controller #(.N_GHOSTS(N), .X_W(XW), .Y_W(YW), .HIT_RADIUS(R), .MAX_LIVES(ML),
    .READY_TICKS(RT), .DEATH_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pacman_x(pacman_x), .pacman_y(pacman_y),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_active(ghost_active), .state(state), .lives(lives),
    .move_en(move_en), .respawn(respawn), .pacman_is_dead(pacman_is_dead), .killer_id(killer_id),
    .game_over(game_over));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rounds modelled as "ticks remaining"; collision is a plain box test on integers
  function automatic void model();
    bit h;
    int k, dx, dy;
    h = 0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      dx = int'(pacman_x) - int'(ghost_x[i*XW +: XW]);
      dy = int'(pacman_y) - int'(ghost_y[i*YW +: YW]);
      if (ghost_active[i] && (dx < 0 ? -dx : dx) < R && (dy < 0 ? -dy : dy) < R) begin
        if (!h) k = i;
        h = 1;
      end
    end
    if (rst) begin
      m_state = 0; m_lives = ML; m_left = 0; m_move = 0; m_resp = 0; m_killer = 0; m_hit = 0; m_kidx = 0;
      return;
    end
    m_move = 0;
    m_resp = 0;
    if ((m_state == 0 || m_state == 4) && start) begin
      m_state = 1; m_lives = ML; m_resp = 1; m_left = RT;
    end else if (m_state == 1 && tick) begin
      m_left--;
      if (m_left == 0) m_state = 2;
    end else if (m_state == 2) begin
      if (m_hit) begin
        m_state = 3; m_lives--; m_killer = m_kidx; m_left = DT;
      end else m_move = tick;
    end else if (m_state == 3 && tick) begin
      m_left--;
      if (m_left == 0) begin
        if (m_lives == 0) m_state = 4;
        else begin m_state = 1; m_resp = 1; m_left = RT; end
      end
    end
    m_hit = h;
    m_kidx = k;
  endfunction

  task automatic step(input logic t, input logic s);
    tick = t;
    start = s;
    model();
    @(posedge clk);
    #1;
    chk("state", state, m_state);
    chk("lives", lives, m_lives);
    chk("move_en", move_en, m_move);
    chk("respawn", respawn, m_resp);
    chk("dead", pacman_is_dead, m_state == 3);
    chk("killer_id", killer_id, m_killer);
    chk("game_over", game_over, m_state == 4);
    @(negedge clk);
  endtask

  task automatic set_ghost(input int i, input int dx, input int dy, input logic act);
    ghost_x[i*XW +: XW] = XW'(int'(pacman_x) + dx);
    ghost_y[i*YW +: YW] = YW'(int'(pacman_y) + dy);
    ghost_active[i] = act;
  endtask

  task automatic far_all();
    for (int i = 0; i < N; i++) set_ghost(i, 200 + 50 * i, 100, logic'($urandom_range(0, 1)));
  endtask

  task automatic run_until(input int tgt, input int maxc, input string tag);
    int c = 0;
    while (m_state != tgt && c < maxc) begin
      step($urandom_range(0, 3) != 0, logic'($urandom_range(0, 1)));
      c++;
    end
    chk(tag, state, tgt);
  endtask

  initial begin
    int gi;
    far_all();
    step(0, 0);
    step(0, 1);
    rst = 0;
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 3);
    step(0, 1);
    chk("start_ready", state, 1);
    chk("start_respawn", respawn, 1);
    step(0, 0);
    chk("respawn_one_cycle", respawn, 0);
    for (int i = 0; i < RT - 1; i++) step(1, 1);
    chk("ready_at_119", state, 1);
    step(1, 0);
    chk("play_at_120", state, 2);
    step(1, 0);
    chk("move_pulse", move_en, 1);
    step(0, 0);
    chk("move_off", move_en, 0);
    set_ghost(2, 16, 0, 1);
    repeat (4) step(1, 0);
    set_ghost(2, -16, 5, 1);
    repeat (4) step(1, 0);
    set_ghost(2, 3, 16, 1);
    repeat (4) step(1, 0);
    chk("no_death_r16", state, 2);
    set_ghost(2, 15, 0, 0);
    repeat (4) step(1, 0);
    chk("no_death_inactive", state, 2);
    set_ghost(2, 15, 0, 1);
    step(0, 0);
    chk("hit_latency1", state, 2);
    step(0, 0);
    chk("death1", state, 3);
    chk("death1_lives", lives, 2);
    chk("death1_killer", killer_id, 2);
    repeat (10) step(1, 1);
    run_until(1, 300, "respawn1");
    far_all();
    run_until(2, 400, "play2");
    set_ghost(1, int'($urandom_range(0, 30)) - 15, int'($urandom_range(0, 30)) - 15, 1);
    set_ghost(3, int'($urandom_range(0, 30)) - 15, int'($urandom_range(0, 30)) - 15, 1);
    step(1, 0);
    step(1, 0);
    chk("death2", state, 3);
    chk("death2_no_move", move_en, 0);
    chk("death2_killer", killer_id, 1);
    chk("death2_lives", lives, 1);
    run_until(1, 300, "respawn2");
    far_all();
    run_until(2, 400, "play3");
    gi = int'($urandom_range(0, N - 1));
    set_ghost(gi, int'($urandom_range(0, 30)) - 15, int'($urandom_range(0, 30)) - 15, 1);
    run_until(3, 10, "death3");
    chk("death3_killer", killer_id, gi);
    run_until(4, 400, "game_over");
    chk("go_lives", lives, 0);
    chk("go_flag", game_over, 1);
    step(1, 0);
    chk("go_hold", state, 4);
    step(0, 1);
    chk("restart_ready", state, 1);
    chk("restart_lives", lives, 3);
    for (int c = 0; c < 6000; c++) begin
      if (c % 40 == 0) begin
        pacman_x = XW'($urandom_range(100, 1900));
        pacman_y = YW'($urandom_range(100, 900));
      end
      for (int i = 0; i < N; i++)
        set_ghost(i, int'($urandom_range(0, 80)) - 40, int'($urandom_range(0, 80)) - 40,
                  logic'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 499) == 0);
      step(logic'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end
    rst = 0;
    pacman_x = 11'd500;
    pacman_y = 10'd300;
    far_all();
    rst = 1;
    step(0, 0);
    rst = 0;
    step(0, 1);
    run_until(2, 400, "play_rst");
    set_ghost(0, 3, -3, 1);
    run_until(3, 10, "dying_rst");
    repeat (20) step(1, 0);
    chk("mid_dying", state, 3);
    rst = 1;
    step(1, 1);
    chk("rst_dying_state", state, 0);
    chk("rst_dying_lives", lives, 3);
    chk("rst_dying_respawn", respawn, 0);
    chk("rst_dying_move", move_en, 0);
    rst = 0;
    step(1, 0);
    chk("post_rst_idle", state, 0);
    chk("post_rst_respawn", respawn, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
